// File: rtl/crc_checker_if.sv
// rtl/crc_checker_if.sv - serial CRC checker link signals; ERR_CNT present with CRC_CHK_ERR_CNT_EN
interface crc_checker_if;
  logic       DATA;
  logic       ACTIVE;
  logic       CRC_IN;
  logic       CRC_VALID;
  logic [7:0] EXP_CRC;
  logic       DONE;
  logic       CRC_OK;
  logic       CRC_ERR;
  logic       BUSY;
`ifdef CRC_CHK_ERR_CNT_EN
  logic [7:0] ERR_CNT;
`endif

  modport master (
    output DATA, ACTIVE, CRC_IN, CRC_VALID,
`ifdef CRC_CHK_ERR_CNT_EN
    input  ERR_CNT,
`endif
    input  EXP_CRC, DONE, CRC_OK, CRC_ERR, BUSY
  );

  modport slave (
    input  DATA, ACTIVE, CRC_IN, CRC_VALID,
`ifdef CRC_CHK_ERR_CNT_EN
    output ERR_CNT,
`endif
    output EXP_CRC, DONE, CRC_OK, CRC_ERR, BUSY
  );
endinterface

// File: rtl/crc_checker.sv
// rtl/crc_checker.sv - serial CRC-8 receive checker; CRC_CHK_ERR_CNT_EN adds a saturating error counter
module crc_checker #(
  parameter logic [7:0] SEED = 8'hD8,
  parameter logic [7:0] TAPS = 8'b10001000
) (
  input logic          CLK,
  input logic          RST,
  crc_checker_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [7:0] exp_crc_q, exp_crc_d;
  logic       done_q, done_d;
  logic       ok_q, ok_d;
  logic       fail_q, fail_d;
  logic       mismatch;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur, input logic din);
    logic       fb;
    logic [7:0] nxt;
    fb     = cur[0] ^ din;
    nxt[7] = fb;
    for (int k = 7; k >= 1; k--) begin
      nxt[k-1] = TAPS[k] ? (cur[k] ^ fb) : cur[k];
    end
    return nxt;
  endfunction

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    exp_crc_d = exp_crc_q;
    done_d    = 1'b0;
    ok_d      = 1'b0;
    fail_d    = 1'b0;
    mismatch  = bus.CRC_IN ^ lfsr_q[0];
    case (state_q)
      ST_IDLE: begin
        if (bus.ACTIVE) begin
          state_d = ST_DATA;
          lfsr_d  = lfsr_step(lfsr_q, bus.DATA);
        end
      end
      ST_DATA: begin
        if (bus.ACTIVE) begin
          lfsr_d = lfsr_step(lfsr_q, bus.DATA);
        end else begin
          state_d   = ST_CHECK;
          exp_crc_d = lfsr_q;
          cnt_d     = 3'd0;
          err_d     = 1'b0;
        end
      end
      ST_CHECK: begin
        // A new data phase during the check aborts it and starts the next frame at once
        if (bus.ACTIVE) begin
          done_d  = 1'b1;
          fail_d  = 1'b1;
          lfsr_d  = lfsr_step(SEED, bus.DATA);
          state_d = ST_DATA;
        end else if (bus.CRC_VALID) begin
          err_d  = err_q | mismatch;
          lfsr_d = {1'b0, lfsr_q[7:1]};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            done_d  = 1'b1;
            ok_d    = ~(err_q | mismatch);
            fail_d  = err_q | mismatch;
            lfsr_d  = SEED;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        lfsr_d  = SEED;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= SEED;
      cnt_q     <= 3'd0;
      err_q     <= 1'b0;
      exp_crc_q <= 8'd0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      exp_crc_q <= exp_crc_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.EXP_CRC = exp_crc_q;
  assign bus.DONE    = done_q;
  assign bus.CRC_OK  = ok_q;
  assign bus.CRC_ERR = fail_q;
  assign bus.BUSY    = (state_q == ST_DATA) || (state_q == ST_CHECK);

`ifdef CRC_CHK_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (done_d && fail_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.ERR_CNT = err_cnt_q;
`else
  // Default build carries no error counter.
`endif
endmodule

// File: tb/tb_crc_checker.sv
// tb/tb_crc_checker.sv - self-checking bench for crc_checker against a frame-level reference model
module tb_crc_checker;
  localparam logic [7:0] SEED = 8'hD8;
  localparam logic [7:0] TAPS = 8'b10001000;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  crc_checker_if bus();

  crc_checker #(.SEED(SEED), .TAPS(TAPS)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // CRC of a whole data frame, straight from the LFSR rule
  function automatic logic [7:0] crc_of(input bit bits[$]);
    logic [7:0] v;
    logic       fb;
    v = SEED;
    foreach (bits[i]) begin
      fb = v[0] ^ bits[i];
      v  = {fb, v[7:1] ^ ({7{fb}} & TAPS[7:1])};
    end
    return v;
  endfunction

  // Frame-level model: collect data bits, then the received CRC byte, compare bytes
  int         m_mode = 0;
  bit         m_bits[$];
  logic [7:0] m_exp = 8'd0;
  logic [7:0] m_rx = 8'd0;
  int         m_n = 0;
  logic       m_done = 1'b0, m_ok = 1'b0, m_err = 1'b0;
  logic [7:0] m_errcnt = 8'd0;
  bit         started = 1'b0;

  task automatic model_step();
    if (!RST) begin
      m_mode = 0; m_exp = 8'd0; m_rx = 8'd0; m_n = 0;
      m_done = 1'b0; m_ok = 1'b0; m_err = 1'b0; m_errcnt = 8'd0;
      m_bits.delete();
    end else begin
      m_done = 1'b0; m_ok = 1'b0; m_err = 1'b0;
      case (m_mode)
        0: if (bus.ACTIVE) begin
          m_bits.delete();
          m_bits.push_back(bus.DATA);
          m_mode = 1;
        end
        1: if (bus.ACTIVE) begin
          m_bits.push_back(bus.DATA);
        end else begin
          m_exp  = crc_of(m_bits);
          m_mode = 2; m_n = 0; m_rx = 8'd0;
        end
        default: if (bus.ACTIVE) begin
          m_done = 1'b1; m_err = 1'b1;
          m_bits.delete();
          m_bits.push_back(bus.DATA);
          m_mode = 1;
        end else if (bus.CRC_VALID) begin
          m_rx[m_n[2:0]] = bus.CRC_IN;
          m_n++;
          if (m_n == 8) begin
            m_done = 1'b1;
            m_ok   = (m_rx == m_exp);
            m_err  = !m_ok;
            m_mode = 0;
          end
        end
      endcase
      if (m_done && m_err && m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
    end
    started = 1'b1;
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (started) begin
      check("done",    {7'd0, bus.DONE},    {7'd0, m_done});
      check("crc_ok",  {7'd0, bus.CRC_OK},  {7'd0, m_ok});
      check("crc_err", {7'd0, bus.CRC_ERR}, {7'd0, m_err});
      check("busy",    {7'd0, bus.BUSY},    {7'd0, (m_mode != 0)});
      check("exp_crc", bus.EXP_CRC, m_exp);
`ifdef CRC_CHK_ERR_CNT_EN
      check("err_cnt", bus.ERR_CNT, m_errcnt);
`endif
    end
  end

  task automatic drive(input logic a, input logic d, input logic v, input logic c);
    @(negedge CLK);
    bus.ACTIVE = a; bus.DATA = d; bus.CRC_VALID = v; bus.CRC_IN = c;
  endtask

  task automatic send_data(input bit bits[$]);
    foreach (bits[i]) drive(1'b1, bits[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic to_check();
    drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_crc(input logic [7:0] b, input int nbits, input int gap_after, input int gap_len);
    for (int i = 0; i < nbits; i++) begin
      drive(1'b0, 1'b0, 1'b1, b[i]);
      if (i == gap_after) repeat (gap_len) drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic expect_done(input logic ok, input logic [7:0] crc, input string tag);
    @(negedge CLK);
    check({tag, "_done"}, {7'd0, bus.DONE},    8'd1);
    check({tag, "_ok"},   {7'd0, bus.CRC_OK},  {7'd0, ok});
    check({tag, "_err"},  {7'd0, bus.CRC_ERR}, {7'd0, !ok});
    check({tag, "_exp"},  bus.EXP_CRC, crc);
    bus.ACTIVE = 1'b0; bus.DATA = 1'b0; bus.CRC_VALID = 1'b0; bus.CRC_IN = 1'b0;
  endtask

  initial begin
    bit         q1[$];
    bit         q4[$];
    bit         pend[$];
    logic [7:0] exp_b, tx_b;
    int         n, abort_at, rst_at;
    logic       d;

    q1 = {1'b1};
    q4 = {1'b0, 1'b0, 1'b0, 1'b0};
    bus.ACTIVE = 1'b0; bus.DATA = 1'b0; bus.CRC_VALID = 1'b0; bus.CRC_IN = 1'b0;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_done", {7'd0, bus.DONE}, 8'd0);
    check("rst_busy", {7'd0, bus.BUSY}, 8'd0);
    check("rst_exp",  bus.EXP_CRC, 8'd0);
    RST = 1'b1;

    check("model_a8", crc_of(q1), 8'hA8);
    check("model_c9", crc_of(q4), 8'hC9);

    send_data(q1); to_check(); send_crc(8'hA8, 8, -1, 0); expect_done(1'b1, 8'hA8, "s1");
    send_data(q4); to_check(); send_crc(8'hC9, 8, -1, 0); expect_done(1'b1, 8'hC9, "s2");
    send_data(q4); to_check(); send_crc(8'hC9 ^ 8'h10, 8, -1, 0); expect_done(1'b0, 8'hC9, "s3");
    send_data(q1); to_check(); send_crc(8'hA8, 8, -1, 0); expect_done(1'b1, 8'hA8, "s3_next");
    send_data(q1); to_check(); send_crc(8'hA8, 8, 3, 3); expect_done(1'b1, 8'hA8, "s4");

    send_data(q4); to_check(); send_crc(8'hC9, 3, -1, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    check("s5_done", {7'd0, bus.DONE},    8'd1);
    check("s5_err",  {7'd0, bus.CRC_ERR}, 8'd1);
    check("s5_ok",   {7'd0, bus.CRC_OK},  8'd0);
    bus.ACTIVE = 1'b0; bus.CRC_VALID = 1'b0;
    @(negedge CLK);
    check("s5_exp", bus.EXP_CRC, 8'hA8);
    send_crc(8'hA8, 8, -1, 0); expect_done(1'b1, 8'hA8, "s5_after");
`ifdef CRC_CHK_ERR_CNT_EN
    check("s5_errcnt", bus.ERR_CNT, 8'd2);
`endif

    send_data(q4); to_check(); send_crc(8'hC9, 3, -1, 0);
    @(negedge CLK);
    RST = 1'b0; bus.CRC_VALID = 1'b0;
    @(negedge CLK);
    check("s6_done", {7'd0, bus.DONE}, 8'd0);
    check("s6_busy", {7'd0, bus.BUSY}, 8'd0);
    check("s6_exp",  bus.EXP_CRC, 8'd0);
    RST = 1'b1;
    send_data(q1); to_check(); send_crc(8'hA8, 8, -1, 0); expect_done(1'b1, 8'hA8, "s6_next");

    for (int f = 0; f < 300; f++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        d = 1'($urandom_range(0, 1));
        pend.push_back(d);
        drive(1'b1, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      to_check();
      exp_b = crc_of(pend);
      pend.delete();
      tx_b = ($urandom_range(0, 3) == 0) ? (exp_b ^ (8'd1 << $urandom_range(0, 7))) : exp_b;
      abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : 99;
      rst_at   = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 7) : 99;
      for (int i = 0; i < 8; i++) begin
        if (i == abort_at) begin
          d = 1'($urandom_range(0, 1));
          pend.push_back(d);
          drive(1'b1, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          break;
        end
        if (i == rst_at) begin
          @(negedge CLK);
          RST = 1'b0; bus.ACTIVE = 1'b0; bus.CRC_VALID = 1'($urandom_range(0, 1));
          @(negedge CLK);
          RST = 1'b1; bus.CRC_VALID = 1'b0;
          break;
        end
        drive(1'b0, 1'b0, 1'b1, tx_b[i]);
        repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      end
      if (pend.size() == 0) begin
        repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
Serial CRC-8 receiver and checker, paired with the serial CRC generator at the other end of the link.
- Recomputes the CRC over a serial data stream using the generator's LFSR.
- Then compares the 8 serially received CRC bits against it.
- Reports pass or fail once per frame.
- Sits on the receive side of the serial link, feeding frame-status logic.

Parameters:
SEED, 8'hD8, LFSR value loaded at reset and at each frame start.
TAPS, 8'b10001000, feedback tap mask; TAPS[k]=1 means the feedback is XORed into the shift from bit k to bit k-1.

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  reset; synchronous, active-low.
DATA  input  1  serial frame data bit; sampled when ACTIVE=1.
ACTIVE  input  1  data-phase qualifier; high for every data bit of a frame.
CRC_IN  input  1  serial received CRC bit, LSB first; sampled when CRC_VALID=1.
CRC_VALID  input  1  qualifier for CRC_IN.
EXP_CRC  output  8  computed CRC, latched when the data phase ends.
DONE  output  1  one-cycle pulse: frame check finished.
CRC_OK  output  1  valid with DONE: all 8 CRC bits matched.
CRC_ERR  output  1  valid with DONE: mismatch or aborted check.
BUSY  output  1  high in the DATA and CHECK states.

Behaviour:
- Reset (RST=0 at a clock edge):
  - State goes to IDLE, LFSR=SEED, bit count=0.
  - EXP_CRC=0, DONE=0, CRC_OK=0, CRC_ERR=0, BUSY=0, error flag cleared.
  - Reset mid-frame discards the frame with no DONE pulse.
- LFSR step, applied once per clock edge with ACTIVE=1:
  - fb = LFSR[0]^DATA.
  - LFSR[7] <= fb.
  - For k=7..1: LFSR[k-1] <= LFSR[k]^fb if TAPS[k], else LFSR[k].
  - This is bit-exact with the generator.
- IDLE:
  - ACTIVE=1 -> DATA state. The LFSR steps from its current value (SEED) in the same cycle.
  - CRC_VALID is ignored.
- DATA:
  - ACTIVE=1 -> step the LFSR and stay in DATA.
  - ACTIVE=0 -> CHECK state. EXP_CRC <= LFSR, count=0, error flag=0.
  - CRC_VALID in this cycle is ignored.
- CHECK:
  - Each cycle with CRC_VALID=1:
    - Compare CRC_IN to LFSR[0]; set the error flag on mismatch (sticky).
    - Shift the LFSR right by 1, with LFSR[7] <= 0.
    - Increment count.
  - CRC_VALID=0 cycles stall with no state change; gaps are allowed.
  - On the 8th qualified bit, DONE=1 on the next cycle, with CRC_OK = !(error flag or this bit's mismatch) and CRC_ERR = its complement.
  - After the 8th bit: LFSR <= SEED, state -> IDLE.
  - Latency: DONE is 1 cycle after the edge sampling the 8th CRC bit.
- Abort: ACTIVE=1 while in CHECK.
  - Pulse DONE=1 with CRC_ERR=1, CRC_OK=0.
  - Reseed the LFSR and consume the current DATA as the first bit of a new frame: LFSR <= step(SEED, DATA).
  - State -> DATA.
- Simultaneous ACTIVE=1 and CRC_VALID=1 in CHECK: abort wins; CRC_IN is ignored.
- DONE, CRC_OK and CRC_ERR are zero in every cycle other than the DONE pulse.
- EXP_CRC holds its value until the next DATA->CHECK transition.
- BUSY is high exactly while the state is DATA or CHECK.

Optional Feature:
Macro: CRC_CHK_ERR_CNT_EN
- Defined:
  - Adds output ERR_CNT[7:0], a saturating count of DONE pulses with CRC_ERR=1. It sticks at 8'hFF.
  - Reset to 0 only by RST.
- Undefined:
  - No ERR_CNT port and no counter logic.
  - All other behaviour is identical.

Test Plan:
1. One data bit DATA=1 (ACTIVE for 1 cycle), then CRC_IN LSB-first 0,0,0,1,0,1,0,1 with CRC_VALID=1 -> EXP_CRC=8'hA8, then DONE=1, CRC_OK=1, CRC_ERR=0.
2. Four data bits 0,0,0,0, then CRC bits 1,0,0,1,0,0,1,1 (8'hC9) -> EXP_CRC=8'hC9, DONE with CRC_OK=1; intermediate LFSR values 6C,36,1B,C9.
3. Same as 2 but the 5th CRC bit is flipped -> DONE with CRC_ERR=1, CRC_OK=0; the next frame (scenario 1) passes, showing the error flag was cleared.
4. Scenario 1 with CRC_VALID low for 3 cycles between bits 4 and 5 -> still CRC_OK=1; DONE comes 1 cycle after the 8th valid bit.
5. Scenario 2, ACTIVE=1 (DATA=1) after 3 CRC bits -> DONE with CRC_ERR=1 that cycle; then ACTIVE=0 -> EXP_CRC=8'hA8.
6. RST=0 mid-CHECK -> all outputs 0 and no DONE pulse; the next scenario-1 frame passes. With CRC_CHK_ERR_CNT_EN, after scenarios 3 and 5 ERR_CNT=2.
